// File: rtl/elementwise_seq.sv
// rtl/elementwise_seq.sv - chunk/vector sequencer for fixed-latency elementwise operators
//
// Purpose: pulls chunks from the producer FIFO and tracks them through the
// operator pipeline. It pushes results into the consumer FIFO under a credit
// rule and reports vector and layer completion.
//
// Ports:
//   clk_in          single clock
//   rst_in          asynchronous active-high reset
//   start           one-cycle pulse, begins a layer run (honoured only in IDLE)
//   in_fifo_empty   producer FIFO empty
//   in_fifo_rd      producer pop (combinational); data arrives next cycle
//   out_fifo_space  free consumer slots (registered by the FIFO)
//   out_fifo_wr     consumer push, aligned with the operator output
//   out_last        with out_fifo_wr: last chunk of its vector
//   chunk_idx       index of the chunk being issued
//   vec_idx         index of the vector being issued
//   vec_done        pulse when a vector's last chunk is pushed
//   busy            high in RUN or DRAIN
//   done            pulse when the final chunk of the run is pushed
module elementwise_seq #(
  parameter int InVecLength = 16,
  parameter int WorkingRegs = 4,
  parameter int NumVectors  = 8,
  parameter int OpLatency   = 1,
  parameter int OutDepth    = 16,
  localparam int ChunksPerVec = (InVecLength + WorkingRegs - 1) / WorkingRegs,
  localparam int CW = $clog2(ChunksPerVec) + 1,
  localparam int VW = $clog2(NumVectors) + 1,
  localparam int SW = $clog2(OutDepth) + 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          start,
  input  logic          in_fifo_empty,
  output logic          in_fifo_rd,
  input  logic [SW-1:0] out_fifo_space,
  output logic          out_fifo_wr,
  output logic          out_last,
  output logic [CW-1:0] chunk_idx,
  output logic [VW-1:0] vec_idx,
  output logic          vec_done,
  output logic          busy,
  output logic          done
);

  localparam int IW = $clog2(OpLatency + 2) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  logic [IW-1:0] inflight;
  logic          issue;
  logic          last_of_vec;
  logic          last_of_run;

  // Each stage carries {valid, last_of_vec, last_of_run}; stage OpLatency is the tail.
  logic [2:0] pipe [0:OpLatency];
  logic [2:0] tail;

  // A chunk may issue only if the consumer can absorb it together with every
  // chunk already in flight, so a push never finds the FIFO full.
  assign issue       = (state == RUN) && !in_fifo_empty &&
                       (int'(out_fifo_space) > int'(inflight));
  assign last_of_vec = (chunk_idx == CW'(ChunksPerVec - 1));
  assign last_of_run = last_of_vec && (vec_idx == VW'(NumVectors - 1));

  assign tail        = pipe[OpLatency];
  assign out_fifo_wr = tail[2];
  assign out_last    = tail[2] & tail[1];
  assign vec_done    = tail[2] & tail[1];
  assign done        = tail[2] & tail[0];

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (issue && last_of_run) state_next = DRAIN;
      DRAIN:   if (done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy       = (state != IDLE);
    in_fifo_rd = issue;
  end

  // Chunk / vector counters; both return to 0 after the final issue so the
  // next run starts from chunk 0, vector 0.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      chunk_idx <= '0;
      vec_idx   <= '0;
    end else if (issue) begin
      if (last_of_vec) begin
        chunk_idx <= '0;
        vec_idx   <= last_of_run ? '0 : vec_idx + VW'(1);
      end else begin
        chunk_idx <= chunk_idx + CW'(1);
      end
    end
  end

  // Chunks issued but not yet pushed
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      inflight <= '0;
    end else begin
      case ({issue, out_fifo_wr})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Valid/last shift register matching the producer read latency plus the
  // operator depth.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i <= OpLatency; i++) pipe[i] <= 3'b000;
    end else begin
      pipe[0] <= {issue, issue & last_of_vec, issue & last_of_run};
      for (int i = 1; i <= OpLatency; i++) pipe[i] <= pipe[i-1];
    end
  end

endmodule

// File: tb/tb_elementwise_seq.sv
// tb/tb_elementwise_seq.sv - scoreboard bench for elementwise_seq
module tb_elementwise_seq;

  localparam int IVL = 10;
  localparam int WR  = 4;
  localparam int NV  = 2;
  localparam int LAT = 1;
  localparam int OD  = 16;
  localparam int CPV = 3;
  localparam int SW  = 5;
  localparam int CW  = 3;
  localparam int VW  = 2;
  localparam int RUN_CHUNKS = CPV * NV;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_fifo_empty;
  logic          in_fifo_rd;
  logic [SW-1:0] out_fifo_space;
  logic          out_fifo_wr;
  logic          out_last;
  logic [CW-1:0] chunk_idx;
  logic [VW-1:0] vec_idx;
  logic          vec_done;
  logic          busy;
  logic          done;

  elementwise_seq #(
    .InVecLength(IVL), .WorkingRegs(WR), .NumVectors(NV),
    .OpLatency(LAT), .OutDepth(OD)
  ) dut (
    .clk_in(clk), .rst_in(rst), .start(start),
    .in_fifo_empty(in_fifo_empty), .in_fifo_rd(in_fifo_rd),
    .out_fifo_space(out_fifo_space), .out_fifo_wr(out_fifo_wr),
    .out_last(out_last), .chunk_idx(chunk_idx), .vec_idx(vec_idx),
    .vec_done(vec_done), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected push stream: {last_of_vec, last_of_run}
  logic [1:0] exp_q [$];
  int pops_left      = 0;
  int exp_chunk      = 0;
  int exp_vec        = 0;
  int bench_inflight = 0;
  int total_pops     = 0;
  int total_pushes   = 0;
  int done_count     = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: checks every pop against the issue model and every push
  // against the scoreboard queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_fifo_rd) begin
        chk("rd_allowed", int'(!in_fifo_empty && (int'(out_fifo_space) > bench_inflight)), 1);
        chk("rd_expected", int'(pops_left > 0), 1);
        chk("chunk_idx", int'(chunk_idx), exp_chunk);
        chk("vec_idx", int'(vec_idx), exp_vec);
        if (pops_left > 0) pops_left--;
        if (exp_chunk == CPV - 1) begin
          exp_chunk = 0;
          exp_vec   = (exp_vec == NV - 1) ? 0 : exp_vec + 1;
        end else begin
          exp_chunk++;
        end
        bench_inflight++;
        total_pops++;
      end
      if (out_fifo_wr) begin
        logic [1:0] e;
        chk("push_expected", int'(exp_q.size() > 0), 1);
        chk("push_has_inflight", int'(bench_inflight > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_last", int'(out_last), int'(e[1]));
          chk("vec_done", int'(vec_done), int'(e[1]));
          chk("done", int'(done), int'(e[0]));
        end
        if (done) done_count++;
        bench_inflight--;
        total_pushes++;
      end else begin
        chk("idle_flags", int'({out_last, vec_done, done}), 0);
      end
    end
  end

  task automatic begin_run();
    for (int v = 0; v < NV; v++)
      for (int c = 0; c < CPV; c++)
        exp_q.push_back({c == CPV - 1, (c == CPV - 1) && (v == NV - 1)});
    pops_left = RUN_CHUNKS;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_seen", int'(i < 300), 1);
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    chk("pushes_eq_pops", total_pushes, total_pops);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int i;
    int n;
    int d0;
    rst            = 1'b1;
    start          = 1'b0;
    in_fifo_empty  = 1'b0;
    out_fifo_space = SW'(16);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_fifo_rd", int'(in_fifo_rd), 0);
    chk("rst_out_fifo_wr", int'(out_fifo_wr), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_chunk_idx", int'(chunk_idx), 0);
    chk("rst_vec_idx", int'(vec_idx), 0);
    chk("rst_vec_done", int'(vec_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Nominal run: issue in the cycle after start, push two cycles after issue
    begin_run();
    chk("busy_after_start", int'(busy), 1);
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_fifo_rd) break;
    end
    chk("first_issue_cycle", i, 0);
    n = 0;
    while (!out_fifo_wr && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("issue_to_push", n, 2);
    wait_done();

    // Back-pressure: one credit, then a window of zero space
    out_fifo_space = SW'(1);
    begin_run();
    repeat (6) @(posedge clk);
    #1 out_fifo_space = SW'(0);
    repeat (8) @(posedge clk);
    #1 out_fifo_space = SW'(1);
    wait_done();
    out_fifo_space = SW'(16);

    // Producer bubbles: empty toggles every cycle
    d0 = done_count;
    begin_run();
    for (i = 0; i < 200 && done_count == d0; i++) begin
      @(posedge clk);
      #1 in_fifo_empty = ~in_fifo_empty;
    end
    in_fifo_empty = 1'b0;
    chk("bubble_done_once", done_count - d0, 1);
    @(negedge clk);
    chk("bubble_busy_low", int'(busy), 0);
    chk("bubble_pushes_eq_pops", total_pushes, total_pops);

    // start during RUN and on the done cycle is ignored
    begin_run();
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("ign_done_seen", int'(i < 300), 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    chk("ign_busy_low", int'(busy), 0);
    chk("ign_pushes_eq_pops", total_pushes, total_pops);
    chk("ign_total_pops", total_pops, 4 * RUN_CHUNKS);

    // Asynchronous reset with two chunks in flight
    begin_run();
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_fifo_rd) break;
    end
    chk("rst_run_first_pop", int'(i < 20), 1);
    @(negedge clk);
    chk("rst_run_second_pop", int'(in_fifo_rd), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_fifo_wr", int'(out_fifo_wr), 0);
    chk("arst_in_fifo_rd", int'(in_fifo_rd), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_chunk_idx", int'(chunk_idx), 0);
    chk("arst_vec_idx", int'(vec_idx), 0);
    chk("arst_flags", int'({out_last, vec_done, done}), 0);
    exp_q.delete();
    pops_left      = 0;
    exp_chunk      = 0;
    exp_vec        = 0;
    bench_inflight = 0;
    total_pops     = 0;
    total_pushes   = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_no_push", total_pushes, 0);
    begin_run();
    wait_done();
    chk("post_rst_run_pushes", total_pushes, RUN_CHUNKS);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elementwise_seq.md
# elementwise_seq

Sequencer for chunked elementwise operators (ReLU, bias-add, clamp) in the inference datapath. It pulls WorkingRegs-wide chunks from the producer FIFO, tracks them through the fixed-latency operator pipeline, and pushes results into the consumer FIFO. It enforces output back-pressure through credits and reports vector and layer completion. It owns all chunk and vector counting, so the operator itself is pure datapath.

## Interface
- InVecLength, 16: elements per vector.
- WorkingRegs, 4: elements per chunk; ChunksPerVec = ceil(InVecLength/WorkingRegs).
- NumVectors, 8: vectors per layer run.
- OpLatency, 1: operator pipeline depth in cycles (0 = combinational).
- OutDepth, 16: consumer FIFO depth in chunks.

Ports:
- clk_in  in  1  single clock.
- rst_in  in  1  reset; asynchronous and active-high.
- start  in  1  one-cycle pulse; begins a layer run; ignored unless IDLE.
- in_fifo_empty  in  1  producer FIFO empty.
- in_fifo_rd  out  1  producer pop (combinational); data valid on the following cycle.
- out_fifo_space  in  $clog2(OutDepth)+1  free consumer slots, registered by the FIFO.
- out_fifo_wr  out  1  consumer push, aligned with operator output.
- out_last  out  1  with out_fifo_wr: chunk is the last of its vector.
- chunk_idx  out  $clog2(ChunksPerVec)+1  index of the chunk being issued.
- vec_idx  out  $clog2(NumVectors)+1  index of the vector being issued.
- vec_done  out  1  one-cycle pulse when a vector's last chunk is pushed.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse when the final chunk of the run is pushed.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start.
  - RUN -> DRAIN on the cycle the final chunk issues.
  - DRAIN -> IDLE on the cycle the final chunk is pushed.
- Issue condition in RUN: issue = !in_fifo_empty && (out_fifo_space > inflight). in_fifo_rd = issue.
- inflight counts issued chunks not yet pushed: +1 on issue, -1 on out_fifo_wr, unchanged when both occur. Range is 0..OpLatency+1.
- On issue, chunk_idx increments. It wraps to 0 after ChunksPerVec-1, and vec_idx increments on that wrap.
- The final issue is chunk_idx = ChunksPerVec-1 and vec_idx = NumVectors-1. No issue occurs in DRAIN or IDLE.
- Valid/last shift register has length 1+OpLatency and carries {valid, last_of_vec, last_of_run}. Its tail drives out_fifo_wr, out_last, vec_done, and done.
- A partial final chunk (InVecLength not a multiple of WorkingRegs) is counted as a full chunk. Masking the unused lanes is the operator's job.
- Reset (any time, including mid-run): state IDLE, counters 0, inflight 0, shift register cleared. Chunks in flight are dropped and not pushed.

## Timing
- Reset values: in_fifo_rd 0, out_fifo_wr 0, out_last 0, chunk_idx 0, vec_idx 0, vec_done 0, busy 0, done 0.
- start in cycle T: busy=1 from T+1. The first issue is possible in T+1.
- An issue in cycle N produces out_fifo_wr in cycle N+1+OpLatency.
- Throughput: one chunk per cycle when the producer is non-empty and space ≥ OpLatency+2.
- Back-pressure: with out_fifo_space=0, no issue occurs. Chunks already in flight are still pushed; the credit rule guarantees a slot for each.
- Producer stall: in_fifo_empty=1 holds the counters. The pipeline keeps draining.
- vec_done and done pulse in the same cycle as the corresponding out_fifo_wr. done and the final vec_done coincide.
- busy drops in the cycle after done. A start in the same cycle as done is ignored.
- A start while busy is ignored with no side effects.

## Test plan
- Nominal run, InVecLength=16, WorkingRegs=4, NumVectors=2, OpLatency=1, producer always full, space=16 -> 8 consecutive out_fifo_wr starting 2 cycles after the first in_fifo_rd. out_last on pushes 4 and 8, vec_done ×2, done with push 8, busy low the next cycle.
- Non-multiple length, InVecLength=10, WorkingRegs=4 -> 3 chunks per vector, out_last on every 3rd push.
- Back-pressure: hold out_fifo_space=1 -> no more than 1 chunk in flight beyond the available space. Total pushes equal total pops, and no push occurs when space=0 and inflight=0.
- Producer bubbles: toggle in_fifo_empty every other cycle -> chunk_idx advances only on pops. Order and counts are preserved, and done fires after exactly ChunksPerVec*NumVectors pushes.
- Assert rst_in asynchronously mid-run with 2 chunks in flight -> all outputs 0 immediately and no pushes after reset. A new start then runs the full sequence from chunk 0, vector 0.
- start pulsed during RUN and on the done cycle -> ignored. Counters and push count are unchanged.
